// File: rtl/snd_pkg.sv
// Shared constants for the sound sequencer: FSM states, sound codes,
// note half-period table and the per-code note sequences.
package snd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [3:0] SND_STOP  = 4'd0;
  localparam logic [3:0] SND_HIT   = 4'd13;
  localparam logic [3:0] SND_END   = 4'd14;
  localparam logic [3:0] SND_START = 4'd15;

  // Tone half-periods in 50 MHz clock cycles, C4..B4.
  localparam logic [16:0] HALF_PER [1:12] = '{
    17'd95556, 17'd90194, 17'd85131, 17'd80354, 17'd75843, 17'd71586,
    17'd67568, 17'd63776, 17'd60197, 17'd56818, 17'd53629, 17'd50619
  };

  localparam logic [3:0] SEQ_LEN [16] = '{
    4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1,
    4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd3, 4'd5, 4'd8
  };

  // Note 0 inside a sequence is a rest.
  localparam logic [3:0] SEQ_NOTES [16][8] = '{
    '{4'd0,  4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
    '{4'd1,  4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
    '{4'd2,  4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
    '{4'd3,  4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
    '{4'd4,  4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
    '{4'd5,  4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
    '{4'd6,  4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
    '{4'd7,  4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
    '{4'd8,  4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
    '{4'd9,  4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
    '{4'd10, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
    '{4'd11, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
    '{4'd12, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
    '{4'd12, 4'd8, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
    '{4'd9,  4'd7, 4'd5, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0},
    '{4'd7,  4'd7, 4'd2, 4'd3, 4'd9, 4'd9, 4'd5, 4'd7}
  };

  // Scaled half-period, never below one cycle; rests map to 1 (unused).
  function automatic logic [16:0] eff_half(input logic [3:0] note,
                                           input int unsigned shift);
    logic [16:0] v;
    v = 17'd1;
    if (note >= 4'd1 && note <= 4'd12) v = HALF_PER[note] >> shift;
    if (v == 17'd0) v = 17'd1;
    return v;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles every `half` enabled cycles, phase and
// output cleared on load or while disabled.
module tone_gen (
  input  logic        clk,
  input  logic        resetN,
  input  logic        load,
  input  logic        enable,
  input  logic [16:0] half,
  output logic        wave
);

  logic [16:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetN || load || !enable) begin
      cnt  <= 17'd0;
      wave <= 1'b0;
    end else if (cnt == half - 17'd1) begin
      cnt  <= 17'd0;
      wave <= ~wave;
    end else begin
      cnt <= cnt + 17'd1;
    end
  end

endmodule

// File: rtl/sound_sequencer.sv
// Plays single notes or note sequences selected by a 4-bit sound code,
// with preemption by equal/higher codes and an immediate stop on code 0.
module sound_sequencer
  import snd_pkg::*;
#(
  parameter int unsigned NOTE_TICKS = 5_000_000,
  parameter int unsigned GAP_TICKS  = 500_000,
  parameter int unsigned DIV_SHIFT  = 0
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [3:0] sndCode,
  input  logic       sndTrg,
  output logic       audOut,
  output logic [3:0] noteIdx,
  output logic       busy,
  output logic       done,
  output logic [1:0] fsm_state
);

  localparam int unsigned MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int unsigned DUR_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(NOTE_TICKS - 1);
  localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'(GAP_TICKS - 1);

  state_e           state, state_n;
  logic [3:0]       code_q, code_n;
  logic [2:0]       step, step_n;
  logic [DUR_W-1:0] dur, dur_n;
  logic [3:0]       note_q, note_n;
  logic             done_n;
  logic             load;
  logic             more_steps, last_gap, start, stop;

  assign more_steps = ({1'b0, step} < (SEQ_LEN[code_q] - 4'd1));
  assign last_gap   = (state == GAP) && (dur == GAP_LAST) && !more_steps;
  // A nonzero trigger on the final gap cycle wins over the natural finish.
  assign start = sndTrg && (sndCode != SND_STOP) &&
                 ((state == IDLE) || (sndCode >= code_q) || last_gap);
  assign stop  = sndTrg && (sndCode == SND_STOP) && (state != IDLE);

  always_comb begin
    state_n = state;
    code_n  = code_q;
    step_n  = step;
    dur_n   = dur;
    note_n  = note_q;
    done_n  = 1'b0;
    load    = 1'b0;
    if (start) begin
      state_n = TONE;
      code_n  = sndCode;
      step_n  = 3'd0;
      dur_n   = '0;
      note_n  = SEQ_NOTES[sndCode][0];
      load    = 1'b1;
    end else if (stop) begin
      state_n = IDLE;
      step_n  = 3'd0;
      dur_n   = '0;
      note_n  = 4'd0;
    end else begin
      case (state)
        TONE: begin
          if (dur == NOTE_LAST) begin
            state_n = GAP;
            dur_n   = '0;
            note_n  = 4'd0;
          end else begin
            dur_n = dur + 1'b1;
          end
        end
        GAP: begin
          if (dur != GAP_LAST) begin
            dur_n = dur + 1'b1;
          end else if (more_steps) begin
            state_n = TONE;
            step_n  = step + 3'd1;
            dur_n   = '0;
            note_n  = SEQ_NOTES[code_q][step + 3'd1];
            load    = 1'b1;
          end else begin
            state_n = IDLE;
            dur_n   = '0;
            step_n  = 3'd0;
            done_n  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state  <= IDLE;
      code_q <= 4'd0;
      step   <= 3'd0;
      dur    <= '0;
      note_q <= 4'd0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      code_q <= code_n;
      step   <= step_n;
      dur    <= dur_n;
      note_q <= note_n;
      done   <= done_n;
    end
  end

  tone_gen u_tone (
    .clk    (clk),
    .resetN (resetN),
    .load   (load),
    .enable ((state_n == TONE) && (note_n != 4'd0)),
    .half   (eff_half(note_q, DIV_SHIFT)),
    .wave   (audOut)
  );

  assign noteIdx   = note_q;
  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer with short note/gap timing; a second
// instance with DIV_SHIFT=17 covers the half-period clamp.
module tb_sound_sequencer;

  logic       clk = 1'b0;
  logic       resetN;
  logic [3:0] sndCode;
  logic       sndTrg;
  logic       audOut, busy, done;
  logic [3:0] noteIdx;
  logic [1:0] fsm_state;
  logic       aud2, busy2, done2;
  logic [3:0] note2;
  logic [1:0] state2;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  sound_sequencer #(.NOTE_TICKS(100), .GAP_TICKS(10), .DIV_SHIFT(10)) dut (
    .clk(clk), .resetN(resetN), .sndCode(sndCode), .sndTrg(sndTrg),
    .audOut(audOut), .noteIdx(noteIdx), .busy(busy), .done(done),
    .fsm_state(fsm_state)
  );

  sound_sequencer #(.NOTE_TICKS(100), .GAP_TICKS(10), .DIV_SHIFT(17)) dut_clamp (
    .clk(clk), .resetN(resetN), .sndCode(sndCode), .sndTrg(sndTrg),
    .audOut(aud2), .noteIdx(note2), .busy(busy2), .done(done2),
    .fsm_state(state2)
  );

  // Counts done pulses of the main instance on the edge after they appear.
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] code;
    int         k;
    logic [3:0] note;
    logic       busy;
    logic       aud;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Ends on the negedge just after the sampling edge (k = 0).
  task automatic trig(input logic [3:0] code);
    sndCode = code;
    sndTrg  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sndTrg  = 1'b0;
  endtask

  task automatic reset_dut();
    resetN = 1'b0;
    step(2);
    resetN = 1'b1;
    step(1);
  endtask

  initial begin
    int c0;
    int k;
    resetN  = 1'b0;
    sndTrg  = 1'b0;
    sndCode = 4'd0;
    step(3);
    chk("rst_aud",   audOut,    0);
    chk("rst_busy",  busy,      0);
    chk("rst_note",  noteIdx,   0);
    chk("rst_done",  done,      0);
    chk("rst_state", fsm_state, 0);
    resetN = 1'b1;
    step(1);

    // {code, cycles after trigger edge, noteIdx, busy, audOut}
    vecs.push_back('{4'd10,   0, 4'd10, 1'b1, 1'b0});
    vecs.push_back('{4'd10,  54, 4'd10, 1'b1, 1'b0});
    vecs.push_back('{4'd10,  55, 4'd10, 1'b1, 1'b1});
    vecs.push_back('{4'd10,  99, 4'd10, 1'b1, 1'b1});
    vecs.push_back('{4'd10, 100, 4'd0,  1'b1, 1'b0});
    vecs.push_back('{4'd10, 109, 4'd0,  1'b1, 1'b0});
    vecs.push_back('{4'd10, 110, 4'd0,  1'b0, 1'b0});
    vecs.push_back('{4'd15, 110, 4'd7,  1'b1, 1'b0});
    vecs.push_back('{4'd15, 220, 4'd2,  1'b1, 1'b0});
    vecs.push_back('{4'd15, 330, 4'd3,  1'b1, 1'b0});
    vecs.push_back('{4'd15, 440, 4'd9,  1'b1, 1'b0});
    vecs.push_back('{4'd15, 550, 4'd9,  1'b1, 1'b0});
    vecs.push_back('{4'd15, 660, 4'd5,  1'b1, 1'b0});
    vecs.push_back('{4'd15, 834, 4'd7,  1'b1, 1'b0});
    vecs.push_back('{4'd15, 835, 4'd7,  1'b1, 1'b1});
    vecs.push_back('{4'd15, 875, 4'd0,  1'b1, 1'b0});
    vecs.push_back('{4'd15, 880, 4'd0,  1'b0, 1'b0});
    vecs.push_back('{4'd14, 330, 4'd0,  1'b1, 1'b0});
    vecs.push_back('{4'd14, 400, 4'd0,  1'b1, 1'b0});
    vecs.push_back('{4'd14, 440, 4'd1,  1'b1, 1'b0});
    vecs.push_back('{4'd14, 533, 4'd1,  1'b1, 1'b1});
    vecs.push_back('{4'd14, 550, 4'd0,  1'b0, 1'b0});
    vecs.push_back('{4'd13,  49, 4'd12, 1'b1, 1'b1});
    vecs.push_back('{4'd13, 110, 4'd8,  1'b1, 1'b0});
    vecs.push_back('{4'd13, 298, 4'd4,  1'b1, 1'b1});
    vecs.push_back('{4'd1,   92, 4'd1,  1'b1, 1'b0});
    vecs.push_back('{4'd1,   93, 4'd1,  1'b1, 1'b1});

    foreach (vecs[i]) begin
      reset_dut();
      trig(vecs[i].code);
      step(vecs[i].k);
      chk($sformatf("v%0d_note", i), noteIdx, vecs[i].note);
      chk($sformatf("v%0d_busy", i), busy,    vecs[i].busy);
      chk($sformatf("v%0d_aud",  i), audOut,  vecs[i].aud);
    end

    // done timing for a single note and the jingle
    reset_dut();
    trig(4'd10);
    k = 0;
    while (!done && k < 1000) begin step(1); k++; end
    chk("done_k_note", k, 110);
    step(1);
    chk("done_pulse_note", done, 0);
    chk("busy_after_note", busy, 0);

    reset_dut();
    c0 = done_cnt;
    trig(4'd15);
    k = 0;
    while (!done && k < 1000) begin step(1); k++; end
    chk("done_k_jingle", k, 880);
    step(2);
    chk("done_once_jingle", done_cnt - c0, 1);

    // reset mid-jingle
    reset_dut();
    trig(4'd15);
    step(300);
    c0 = done_cnt;
    resetN = 1'b0;
    step(1);
    chk("midrst_aud",  audOut,  0);
    chk("midrst_busy", busy,    0);
    chk("midrst_note", noteIdx, 0);
    step(2);
    resetN = 1'b1;
    step(900);
    chk("midrst_nodone", done_cnt - c0, 0);
    chk("midrst_idle",   busy,          0);

    // preempt 13 by 15
    reset_dut();
    trig(4'd13);
    step(20);
    trig(4'd15);
    chk("preempt_note", noteIdx, 7);
    chk("preempt_aud",  audOut,  0);
    step(110);
    chk("preempt_note2", noteIdx, 7);
    step(110);
    chk("preempt_note3", noteIdx, 2);

    // lower code ignored during jingle
    reset_dut();
    trig(4'd15);
    step(20);
    trig(4'd13);
    chk("ignore_note", noteIdx, 7);
    step(199);
    chk("ignore_note_k220", noteIdx, 2);

    // stop with code 0
    reset_dut();
    trig(4'd15);
    step(50);
    c0 = done_cnt;
    trig(4'd0);
    chk("stop_busy",  busy,      0);
    chk("stop_note",  noteIdx,   0);
    chk("stop_aud",   audOut,    0);
    chk("stop_state", fsm_state, 0);
    step(900);
    chk("stop_nodone", done_cnt - c0, 0);

    // trigger on the final gap cycle wins over done
    reset_dut();
    c0 = done_cnt;
    trig(4'd10);
    step(109);
    trig(4'd5);
    chk("win_note", noteIdx, 5);
    chk("win_busy", busy,    1);
    chk("win_done", done,    0);
    step(2);
    chk("win_nodone", done_cnt - c0, 0);

    // clamp: DIV_SHIFT=17 toggles every cycle in TONE
    reset_dut();
    trig(4'd10);
    chk("clamp_k0", aud2, 0);
    step(1);
    chk("clamp_k1", aud2, 1);
    step(1);
    chk("clamp_k2", aud2, 0);
    step(97);
    chk("clamp_k99", aud2, 1);
    step(1);
    chk("clamp_k100", aud2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
- Downstream of the game controller: consumes its 4-bit sound code plus a one-cycle trigger and produces a square-wave audio bit for the board audio pin.
- Plays either a single note or a multi-note jingle, timed entirely by clock counters (no delay constructs), so event sounds and the start-of-game jingle are synthesizable.
- Sits between the controller and the audio output driver.

Parameters:
- NOTE_TICKS, 5_000_000, clock cycles each note sounds (100 ms at 50 MHz).
- GAP_TICKS, 500_000, silent clock cycles after every note.
- DIV_SHIFT, 0, right-shift applied to every tone half-period; used to shorten runs in simulation.

Ports:
- clk  in  1  system clock.
- resetN  in  1  synchronous active-low reset.
- sndCode  in  4  sound request code from controller; sampled only when sndTrg=1.
- sndTrg  in  1  one-cycle request strobe.
- audOut  out  1  square-wave audio output.
- noteIdx  out  4  note currently sounding; 0 = silence or rest.
- busy  out  1  high while a sound is in progress.
- done  out  1  one-cycle pulse when a sequence finishes naturally.

Behaviour:
- Interface (already decided): one clock, clk; reset resetN is synchronous and active-low, so all state changes only on rising clk.
- Reset values: state IDLE; audOut=0, noteIdx=0, busy=0, done=0; all counters 0.
- Reset mid-sound aborts at the next clk edge with no done pulse.
- Sound codes:
  - 0 = stop.
  - 1..12 = single note, C4..B4 semitones.
  - 13 = hit sequence {12,8,4}.
  - 14 = end sequence {9,7,5,0,1}, where 0 = rest.
  - 15 = start jingle {7,7,2,3,9,9,5,7}.
  - A single note is a sequence of length 1.
- FSM has three states: IDLE, TONE, GAP.
  - IDLE: on sndTrg with sndCode!=0, latch the code and set step=0. In the next cycle the state is TONE, noteIdx = seq[code][0], busy=1.
  - TONE: a duration counter runs for exactly NOTE_TICKS cycles, then the state goes to GAP.
    - The half-period counter toggles audOut when it reaches halfPer(noteIdx)-1, then reloads to 0.
    - audOut starts at 0 on entry to each TONE.
    - For a rest (noteIdx=0), audOut is held at 0 for the whole TONE.
  - GAP: audOut=0 and noteIdx=0 for GAP_TICKS cycles. Then:
    - if step < len-1: step+1 and back to TONE;
    - otherwise: IDLE, busy=0, done=1 for one cycle.
- Latency: trigger at edge t gives first audible note at t+1. Total sequence length is len×(NOTE_TICKS+GAP_TICKS) cycles.
- Half-periods at 50 MHz come from a package table, index 1..12: 95556, 90194, 85131, 80354, 75843, 71586, 67568, 63776, 60197, 56818, 53629, 50619.
  - The effective value is table>>DIV_SHIFT, clamped to a minimum of 1.
  - The half-period counter is 17 bits; the duration counter is sized to max(NOTE_TICKS, GAP_TICKS) with no wrap.
- Trigger while busy:
  - sndCode=0: immediate stop. Next cycle is IDLE, audOut=0, no done.
  - sndCode >= latched code: preempt. Restart at step 0 of the new code next cycle, with counters cleared.
  - sndCode < latched code: ignored.
- Trigger in the same cycle that GAP would finish the last note: the trigger wins. Restart the new code; no done pulse.
- sndTrg held high for several cycles: each cycle is evaluated independently. An equal code therefore restarts repeatedly, and the controller must pulse sndTrg.
- Codes outside the tables cannot occur (4-bit, fully defined); codes 1..12 map to len=1.

Decomposition:
- Package snd_pkg holds:
  - the state enum;
  - the HALF_PER table (12×17-bit);
  - SEQ_LEN[16] and SEQ_NOTES[16][8] (4-bit entries);
  - code constants SND_STOP=0, SND_HIT=13, SND_END=14, SND_START=15.
- One natural sub-module, tone_gen: takes the half-period and an enable, and outputs the square wave, restarting phase on a load pulse. The sequencer FSM and duration counting stay in sound_sequencer.

Test Plan:
All scenarios use NOTE_TICKS=100, GAP_TICKS=10, DIV_SHIFT=10.
- Reset: hold resetN=0 for 3 cycles mid-jingle. After the next edge: audOut=0, busy=0, noteIdx=0, done never asserted.
- Single note: sndTrg with code 10 (A4, half-period 56818>>10=55).
  - busy=1 one cycle later; audOut toggles every 55 cycles during 100 TONE cycles, then 10 cycles low.
  - done pulses once at cycle 111; busy=0 after.
- Start jingle: code 15. noteIdx sequence is 7,7,2,3,9,9,5,7, each held 100 cycles with 10-cycle gaps of noteIdx=0. done occurs at cycle 881.
- Rest: code 14. The fourth note has noteIdx=0 and audOut stays 0 for its 100 TONE cycles; the remaining notes play normally.
- Preemption:
  - During code 13, trigger code 15: restart with noteIdx=7 next cycle.
  - During code 15, trigger code 13: ignored, jingle continues.
  - Trigger code 0: IDLE next cycle, no done.
- Clamp: DIV_SHIFT=17. Every half-period clamps to 1, so audOut toggles every cycle in TONE.
